// File: rtl/rca_bist_pkg.sv
// Shared definitions for the ripple-carry-adder BIST controller: FSM state
// encoding, sweep vector geometry, error-counter geometry and the reference
// result function used to judge each adder response.
package rca_bist_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Sweep vector is {a[3:0], b[3:0], cin}; cin is the LSB.
  localparam int unsigned VEC_W = 9;
  localparam logic [VEC_W-1:0] VEC_LAST = 9'h1FF;

  // Operand width of the adder under test.
  localparam int unsigned OPD_W = 4;

  // Error counter width and its saturation value.
  localparam int unsigned ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

  // Width of the settle down-counter; holds SETTLE values 1..15.
  localparam int unsigned CNT_W = 4;

  // Reference result {cout, sum} for a sweep vector: a + b + cin, zero-extended.
  function automatic logic [OPD_W:0] exp_result(input logic [VEC_W-1:0] vec);
    logic [OPD_W:0] a_ext;
    logic [OPD_W:0] b_ext;
    logic [OPD_W:0] c_ext;
    a_ext = {1'b0, vec[8:5]};
    b_ext = {1'b0, vec[4:1]};
    c_ext = {4'b0000, vec[0]};
    return a_ext + b_ext + c_ext;
  endfunction

endpackage : rca_bist_pkg

// File: rtl/rca_bist.sv
// Exhaustive BIST controller for an external 4-bit ripple-carry adder.
// Drives every {a,b,cin} combination in ascending order, holds each vector
// for SETTLE cycles, then compares the returned {cout,sum} against the
// reference sum. Counts mismatches (saturating) and captures the first
// failing vector. All outputs come straight from flops.
module rca_bist
  import rca_bist_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [OPD_W-1:0]  a,
  output logic [OPD_W-1:0]  b,
  output logic              cin,
  input  logic [OPD_W-1:0]  sum,
  input  logic              cout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              fail_valid,
  output logic [VEC_W-1:0]  fail_vec
);

  // Settle-counter reload value, cast once to the counter width.
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

  // Registered state.
  state_e             state_q,      state_d;
  logic [VEC_W-1:0]   vec_q,        vec_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [ERR_W-1:0]   err_q,        err_d;
  logic               fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0]   fail_vec_q,   fail_vec_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic               pass_q,       pass_d;

  // Response judgement for the vector currently on the bus.
  logic [OPD_W:0]     expected;
  logic               mismatch;

  // Compare the adder response against the reference sum of the driven vector.
  always_comb begin
    expected = exp_result(vec_q);
    mismatch = ({cout, sum} != expected);
  end

  // Next-state and next-output computation for the sweep sequencer.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A sweep can only be launched while not busy; starts elsewhere are dropped.
        if (start) begin
          state_d      = ST_WAIT;
          vec_d        = {VEC_W{1'b0}};
          cnt_d        = SETTLE_LD;
          err_d        = {ERR_W{1'b0}};
          fail_valid_d = 1'b0;
          fail_vec_d   = {VEC_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end

      ST_WAIT: begin
        // cnt_q counts remaining settle cycles including the current one.
        if (cnt_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 8'd1;
          end else begin
            err_d = err_q;
          end
          // Only the first failing vector of a sweep is kept.
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end else begin
            fail_vec_d   = fail_vec_q;
          end
        end else begin
          err_d = err_q;
        end

        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          // Next vector goes out on the same edge that re-enters WAIT.
          vec_d   = vec_q + 9'd1;
          cnt_d   = SETTLE_LD;
          state_d = ST_WAIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are derived from the next state so they are registered
    // alongside it and line up with the state they describe.
    busy_d = (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      pass_d = (err_d == {ERR_W{1'b0}});
    end else begin
      pass_d = 1'b0;
    end
  end

  // Single state register for the sequencer and all of its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= {VEC_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      err_q        <= {ERR_W{1'b0}};
      fail_valid_q <= 1'b0;
      fail_vec_q   <= {VEC_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // Vector fields come directly from the vector register.
  assign a          = vec_q[8:5];
  assign b          = vec_q[4:1];
  assign cin        = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule : rca_bist
